// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the single-port RAM arbiter: response tag encoding
// and the bit positions of each requester in the request/grant vectors.
// The bit positions are listed from highest to lowest fixed priority.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  // Tag carried alongside each RAM access so that the returning read data
  // can be steered to the requester that issued it.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DM   = 2'd1,
    TAG_IF   = 2'd2,
    TAG_DBG  = 2'd3
  } tag_t;

  // Request/grant vector positions. A lower value means a higher priority.
  localparam int unsigned PRIO_DM  = 0;
  localparam int unsigned PRIO_IF  = 1;
  localparam int unsigned PRIO_DBG = 2;
  localparam int unsigned N_REQ    = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arb_if
// Bundles every signal between the arbiter, its three requesters (DM, IF,
// DBG) and the shared single-port RAM.
//   slave  : the arbiter's view (requests and RAM read data in; acks,
//            rvalids, shared rdata and RAM controls out)
//   master : the view of the surrounding system (requesters plus RAM)
// Byte addresses are full 32-bit; the RAM address is AW bits wide.
// ---------------------------------------------------------------------------
interface mem_arb_if #(
  parameter int unsigned AW = 8
);
  // Data-access stage
  logic          dm_req;
  logic [3:0]    dm_wen;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ack;
  logic          dm_rvalid;
  // Instruction-fetch stage
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ack;
  logic          if_rvalid;
  // Display/debug port
  logic          dbg_req;
  logic [31:0]   dbg_addr;
  logic          dbg_ack;
  logic          dbg_rvalid;
  // Shared read data
  logic [31:0]   rdata;
  // RAM side
  logic          ram_en;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  dm_req, dm_wen, dm_addr, dm_wdata,
    input  if_req, if_addr,
    input  dbg_req, dbg_addr,
    input  ram_rdata,
    output dm_ack, dm_rvalid, if_ack, if_rvalid, dbg_ack, dbg_rvalid,
    output rdata,
    output ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output dm_req, dm_wen, dm_addr, dm_wdata,
    output if_req, if_addr,
    output dbg_req, dbg_addr,
    output ram_rdata,
    input  dm_ack, dm_rvalid, if_ack, if_rvalid, dbg_ack, dbg_rvalid,
    input  rdata,
    input  ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arb_resp_pipe.sv
// ---------------------------------------------------------------------------
// mem_arb_resp_pipe
// RAM_LAT-deep shift register of response tags. A tag entering this cycle
// leaves RAM_LAT cycles later, exactly when the RAM presents the matching
// read data, and is decoded into one-hot rvalid strobes.
// Ports:
//   clk, resetn     clock, synchronous active-low clear
//   tag_i           tag of the access issued this cycle (TAG_NONE if idle/write)
//   dm_rvalid_o     exiting tag is TAG_DM
//   if_rvalid_o     exiting tag is TAG_IF
//   dbg_rvalid_o    exiting tag is TAG_DBG
// ---------------------------------------------------------------------------
module mem_arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic clk,
  input  logic resetn,
  input  tag_t tag_i,
  output logic dm_rvalid_o,
  output logic if_rvalid_o,
  output logic dbg_rvalid_o
);

  tag_t pipe_q [RAM_LAT];
  tag_t pipe_d [RAM_LAT];

  always_comb begin
    pipe_d[0] = tag_i;
    for (int i = 1; i < RAM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: unlike a data RAM, this tag store must be reset: its contents
  // qualify the rvalid strobes, so stale tags would fabricate responses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        pipe_q[i] <= TAG_NONE;
      end
    end else begin
      // NOTE: non-blocking assignment lets every stage sample the previous
      // stage's old value, which is what makes this a shift register.
      pipe_q <= pipe_d;
    end
  end

  assign dm_rvalid_o  = (pipe_q[RAM_LAT-1] == TAG_DM);
  assign if_rvalid_o  = (pipe_q[RAM_LAT-1] == TAG_IF);
  assign dbg_rvalid_o = (pipe_q[RAM_LAT-1] == TAG_DBG);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous RAM among the data-access stage (DM,
// read/write), the instruction-fetch stage (IF, read) and the debug port
// (DBG, read). Grants one access per cycle combinationally with fixed
// priority DM > IF > DBG, except that DBG is forced through once it has
// lost arbitration STARVE_LIMIT consecutive cycles. Read data returns
// RAM_LAT cycles after the grant, flagged by the issuer's rvalid.
// Ports:
//   clk     clock
//   resetn  synchronous active-low reset; suppresses all grants while low
//   bus     mem_arb_if.slave: requester handshakes, shared rdata, RAM port
// Parameters:
//   AW            RAM word-address width (byte address bits [AW+1:2])
//   RAM_LAT       RAM read latency, 1..3
//   STARVE_LIMIT  DBG losses before a forced grant, 1..255
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 8,
  parameter int unsigned RAM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic       clk,
  input  logic       resetn,
  mem_arb_if.slave   bus
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [7:0]       starve_cnt_q;
  logic [7:0]       starve_cnt_d;
  logic             dbg_force;
  logic [31:0]      win_addr;
  logic [3:0]       win_wen;
  tag_t             win_tag;
  logic             unused_addr_bits;

  assign req[PRIO_DM]  = bus.dm_req;
  assign req[PRIO_IF]  = bus.if_req;
  assign req[PRIO_DBG] = bus.dbg_req;

  assign dbg_force = bus.dbg_req && (starve_cnt_q == 8'(STARVE_LIMIT));

  // Grant: starvation override first, then fixed priority.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so
    // that no path leaves it unassigned and infers a latch.
    gnt = '0;
    if (resetn) begin
      if (dbg_force)           gnt[PRIO_DBG] = 1'b1;
      else if (req[PRIO_DM])   gnt[PRIO_DM]  = 1'b1;
      else if (req[PRIO_IF])   gnt[PRIO_IF]  = 1'b1;
      else if (req[PRIO_DBG])  gnt[PRIO_DBG] = 1'b1;
    end
  end

  // Counts consecutive cycles in which DBG wants the RAM but loses.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.dbg_req || gnt[PRIO_DBG]) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < 8'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) starve_cnt_q <= '0;
    else         starve_cnt_q <= starve_cnt_d;
  end

  // Issue mux: steer the winner's address and write enables to the RAM.
  // Only DM can write; a DM write carries TAG_NONE so it yields no rvalid.
  always_comb begin
    win_addr = bus.dbg_addr;
    win_wen  = 4'b0000;
    win_tag  = TAG_NONE;
    if (gnt[PRIO_DM]) begin
      win_addr = bus.dm_addr;
      win_wen  = bus.dm_wen;
      win_tag  = (bus.dm_wen == 4'b0000) ? TAG_DM : TAG_NONE;
    end else if (gnt[PRIO_IF]) begin
      win_addr = bus.if_addr;
      win_tag  = TAG_IF;
    end else if (gnt[PRIO_DBG]) begin
      win_tag  = TAG_DBG;
    end
  end

  // Byte-offset bits and bits above the RAM's reach are deliberately dropped.
  assign unused_addr_bits = ^{win_addr[31:AW+2], win_addr[1:0]};

  assign bus.ram_en    = |gnt;
  assign bus.ram_wen   = win_wen;
  assign bus.ram_addr  = win_addr[AW+1:2];
  assign bus.ram_wdata = bus.dm_wdata;

  assign bus.dm_ack  = gnt[PRIO_DM];
  assign bus.if_ack  = gnt[PRIO_IF];
  assign bus.dbg_ack = gnt[PRIO_DBG];

  assign bus.rdata   = bus.ram_rdata;

  mem_arb_resp_pipe #(
    .RAM_LAT (RAM_LAT)
  ) u_resp_pipe (
    .clk          (clk),
    .resetn       (resetn),
    .tag_i        (win_tag),
    .dm_rvalid_o  (bus.dm_rvalid),
    .if_rvalid_o  (bus.if_rvalid),
    .dbg_rvalid_o (bus.dbg_rvalid)
  );

endmodule
